ram_readout: RTL and testbench
==============================

Name: ram_readout

Overview:
- Read-side engine for the ADC sample capture RAM controller.
- After a capture completes (the capture controller's wr_end is high), it walks the RAM from a base address, driving rd_addr/rd_en.
- It absorbs the RAM read latency and presents samples as a valid/ready stream toward the host link.
- Credit-based issue plus a small output FIFO guarantee no sample loss under backpressure.

Parameters:
ADDR_W, 10, RAM address width
DATA_W, 12, sample width
NUM_SAMPLES, 256, samples per readout (1..2^ADDR_W)
RD_LAT, 2, cycles from rd_en/rd_addr asserted to ram_data valid (>=1)
FIFO_DEPTH, 4, output FIFO entries (>= RD_LAT+1, power of 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle readout request
base_addr  in  ADDR_W  first address, sampled on accepted start
wr_end  in  1  capture-complete level from the capture controller (1 = RAM stable)
rd_addr  out  ADDR_W  RAM read address
rd_en  out  1  RAM read enable, one read per high cycle
ram_data  in  DATA_W  RAM read data, valid RD_LAT cycles after rd_en
m_data  out  DATA_W  stream sample
m_valid  out  1  stream valid
m_ready  in  1  stream ready
m_last  out  1  high with final sample (index NUM_SAMPLES-1)
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after last sample accepted
err  out  1  sticky abort flag, cleared by next accepted start

Behaviour:
- Reset (sync, rst=1 at a clk edge): state IDLE; rd_addr=0, rd_en=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0, err=0. FIFO and in-flight tracker are flushed. Reset overrides everything, including mid-readout.
- FSM states: IDLE, WAIT_CAP, READ, DRAIN, DONE.
- IDLE: start=1 -> WAIT_CAP. Latch base_addr; clear issue count, accept count and err.
- WAIT_CAP: stay while wr_end=0. wr_end=1 -> READ.
- READ, issue rule:
  - rd_en=1 in a cycle iff issued < NUM_SAMPLES and (fifo_count + in_flight) < FIFO_DEPTH.
  - rd_addr = base + issued, modulo 2^ADDR_W (wraps, e.g. 1023 -> 0).
  - When the last read issues -> DRAIN.
- In-flight tracking: RD_LAT-deep shift register of {valid, last}. The entry emerging at tap RD_LAT writes ram_data into the FIFO in that cycle. The last flag rides alongside the data.
- Output: m_valid = FIFO non-empty. m_data/m_last come from the FIFO head. Pop when m_valid and m_ready are both 1.
- DRAIN: wait until in_flight=0, FIFO empty and the last beat is accepted -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- Abort: wr_end falls in READ or DRAIN (a new capture started).
  - Next cycle: err=1, FIFO and in-flight flushed, m_valid=0, rd_en=0, state IDLE.
  - done is not pulsed.
- start while busy=1: ignored, with no effect on state or addresses.
- rd_en and the FIFO push in the same cycle: both allowed. Credit counts the push before the pop.
- Latency with m_ready=1:
  - start at cycle 0, wr_end=1 -> WAIT_CAP at cycle 1 -> READ at cycle 2.
  - First rd_en at cycle 2; first m_valid at cycle 3+RD_LAT.
  - Steady throughput is 1 sample/cycle.
- rd_addr holds its last value when rd_en=0.
- Invariant: fifo_count + in_flight <= FIFO_DEPTH at all times.

Test Plan:
- Basic run (RD_LAT=2, RAM model q=addr+0x100, base=0, wr_end=1, m_ready=1, start at cycle 0):
  - rd_en high at cycles 2..257.
  - 256 beats with m_data=0x100..0x1FF; first m_valid at cycle 5.
  - m_last only on beat 255; done pulse once; busy falls the cycle after done.
- Backpressure: m_ready=0 for cycles 6..30, then toggling 1/0.
  - Outstanding reads never exceed 4; rd_en stalls.
  - All 256 beats arrive in order, no duplicates; m_data stable while m_valid=1 and m_ready=0.
- Wait and wrap: wr_end=0 at start, raised 15 cycles later; base_addr=1000.
  - No rd_en before wr_end rises.
  - Addresses run 1000..1023, then 0..231; m_last on address 231.
- Abort: wr_end drops after the 100th read.
  - err=1 the next cycle; m_valid=0; IDLE; no done.
  - A following start clears err, and a full run completes.
- Reset and restart:
  - rst asserted mid-READ -> all outputs at reset values next cycle.
  - A start pulsed during busy is ignored (beat count stays 256).

Source files
------------

// File: rtl/ram_readout.sv
// ram_readout: read-side engine for the ADC sample capture RAM.
// Walks the RAM from a latched base address once the capture is stable,
// absorbs the RAM read latency in a shift register and presents samples
// as a valid/ready stream. Reads are only issued while the output FIFO is
// guaranteed to have room for them, so backpressure never drops a sample.
module ram_readout #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 12,
    parameter int NUM_SAMPLES = 256,
    parameter int RD_LAT      = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              wr_end,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam int USED_W = PTR_W + 2;
    localparam logic [CNT_W-1:0]  NUM_S    = CNT_W'(NUM_SAMPLES);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [USED_W-1:0] DEPTH_U  = USED_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CAP,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t state;

    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  accepted;
    logic [CNT_W-1:0]  issued_next;

    logic [RD_LAT-1:0] vld_sr;
    logic [RD_LAT-1:0] lst_sr;

    logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] fifo_count;
    logic [DATA_W:0]   fifo_head;

    logic [USED_W-1:0] in_flight;
    logic [USED_W-1:0] used;
    logic [USED_W-1:0] used_next;
    logic              fifo_push;
    logic              fifo_pop;
    logic              can_issue;
    logic              abort;
    logic              issue_last;

    assign m_valid   = (fifo_count != '0);
    assign fifo_head = fifo_mem[rd_ptr];
    assign m_data    = m_valid ? fifo_head[DATA_W-1:0] : '0;
    assign m_last    = m_valid && fifo_head[DATA_W];
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // Credit accounting: a read may issue next cycle only if FIFO entries plus reads in flight stay below the depth.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + USED_W'(vld_sr[i]);
        end
        abort       = ((state == READ) || (state == DRAIN)) && !wr_end;
        fifo_push   = vld_sr[RD_LAT-1];
        fifo_pop    = m_valid && m_ready;
        used        = USED_W'(fifo_count) + in_flight;
        used_next   = used + USED_W'(rd_en) - USED_W'(fifo_pop);
        issued_next = issued + CNT_W'(rd_en);
        can_issue   = (issued_next < NUM_S) && (used_next < DEPTH_U);
        issue_last  = rd_en && (issued == LAST_IDX);
    end

    // Control FSM with registered read port; rd_en/rd_addr are decided one cycle ahead from the predicted credit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base_q   <= '0;
            issued   <= '0;
            accepted <= '0;
            err      <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
        end else begin
            rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        issued   <= '0;
                        accepted <= '0;
                        err      <= 1'b0;
                        state    <= WAIT_CAP;
                    end
                end
                WAIT_CAP: begin
                    if (wr_end) begin
                        state <= READ;
                        rd_en <= can_issue;
                        if (can_issue) begin
                            rd_addr <= base_q + issued_next[ADDR_W-1:0];
                        end
                    end
                end
                READ: begin
                    if (abort) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        issued   <= issued_next;
                        accepted <= accepted + CNT_W'(fifo_pop);
                        rd_en    <= can_issue;
                        if (can_issue) begin
                            rd_addr <= base_q + issued_next[ADDR_W-1:0];
                        end
                        if (issued_next == NUM_S) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (fifo_pop) begin
                        accepted <= accepted + CNT_W'(1);
                        if (accepted == LAST_IDX) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // In-flight tracker and FIFO pointers; an abort flushes them just like reset.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            vld_sr     <= '0;
            lst_sr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            vld_sr[0] <= rd_en;
            lst_sr[0] <= issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                lst_sr[i] <= lst_sr[i-1];
            end
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= fifo_count + FCNT_W'(fifo_push) - FCNT_W'(fifo_pop);
        end
    end

    // FIFO storage: RAM data is captured together with its last flag as it leaves the latency pipeline.
    always_ff @(posedge clk) begin
        if (fifo_push && !abort) begin
            fifo_mem[wr_ptr] <= {lst_sr[RD_LAT-1], ram_data};
        end
    end

endmodule

// File: tb/tb_ram_readout.sv
// tb_ram_readout: self-checking bench for ram_readout with a RAM model
// returning q = addr + 0x100 after two cycles.
module tb_ram_readout;

    localparam int ADDR_W      = 10;
    localparam int DATA_W      = 12;
    localparam int NUM_SAMPLES = 256;
    localparam int RD_LAT      = 2;
    localparam int FIFO_DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              wr_end;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              busy;
    logic              done;
    logic              err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [ADDR_W-1:0] run_base;
    int                n_issued;
    int                n_accepted;
    int                first_rd;
    int                last_rd;
    int                first_valid;
    int                done_cnt;
    int                done_cyc;
    int                last_cnt;
    int                max_out;
    logic [DATA_W-1:0] last_data;
    logic              prev_stall;
    logic [DATA_W-1:0] prev_data;

    typedef struct {
        logic              s;
        logic              we;
        logic              rdy;
        logic              e_rd_en;
        logic [ADDR_W-1:0] e_addr;
        logic              e_valid;
        logic [DATA_W-1:0] e_data;
        logic              e_busy;
    } vec_t;

    vec_t vecs [8];

    logic [DATA_W-1:0] ram_pipe [RD_LAT];

    ram_readout #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .NUM_SAMPLES(NUM_SAMPLES),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .wr_end   (wr_end),
        .rd_addr  (rd_addr),
        .rd_en    (rd_en),
        .ram_data (ram_data),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // RAM model: registered read with RD_LAT stages, content is address + 0x100.
    always @(posedge clk) begin
        ram_pipe[0] <= {2'b00, rd_addr} + 12'h100;
        for (int i = 1; i < RD_LAT; i++) begin
            ram_pipe[i] <= ram_pipe[i-1];
        end
    end
    assign ram_data = ram_pipe[RD_LAT-1];

    // Hard stop in case something never terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic resetContext(input logic [ADDR_W-1:0] b);
        run_base    = b;
        n_issued    = 0;
        n_accepted  = 0;
        first_rd    = -1;
        last_rd     = -1;
        first_valid = -1;
        done_cnt    = 0;
        done_cyc    = -1;
        last_cnt    = 0;
        max_out     = 0;
        last_data   = '0;
        prev_stall  = 1'b0;
        prev_data   = '0;
        cyc         = 0;
    endtask

    // Scoreboard for one sampled cycle: issue credit, addresses, beat order and hold-under-stall.
    task automatic monitorSample();
        int                outst;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] exp_d;
        outst = n_issued - n_accepted;
        if (rd_en === 1'b1) begin
            checkOutput("credit", 32'(outst < FIFO_DEPTH), 32'd1);
            a = run_base + ADDR_W'(n_issued);
            checkOutput("rd_addr", 32'(rd_addr), 32'(a));
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            n_issued++;
            if (outst + 1 > max_out) max_out = outst + 1;
        end
        if (prev_stall) begin
            checkOutput("hold_valid", 32'(m_valid), 32'd1);
            checkOutput("hold_data", 32'(m_data), 32'(prev_data));
        end
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (m_valid && m_ready) begin
            a     = run_base + ADDR_W'(n_accepted);
            exp_d = {2'b00, a} + 12'h100;
            checkOutput("beat_data", 32'(m_data), 32'(exp_d));
            checkOutput("beat_last", 32'(m_last), 32'(n_accepted == NUM_SAMPLES - 1));
            if (m_last) begin
                last_cnt++;
                last_data = m_data;
            end
            n_accepted++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic we, input logic rdy,
                                 input logic [ADDR_W-1:0] ba);
        @(posedge clk);
        #1;
        rst       = r;
        start     = s;
        wr_end    = we;
        m_ready   = rdy;
        base_addr = ba;
        @(negedge clk);
        monitorSample();
        cyc++;
    endtask

    function automatic logic readyFor(input int mode, input int c);
        if (mode == 1) begin
            if (c >= 6 && c <= 30) return 1'b0;
            if (c > 30) return (c % 2 == 1);
        end
        return 1'b1;
    endfunction

    // Runs with wr_end=1 until done or the cycle budget expires; mode 2 pulses an ignored start at cycle 20.
    task automatic runToDone(input int max_cycles, input int mode);
        int i;
        i = 0;
        while (done_cnt == 0 && i < max_cycles) begin
            if (mode == 2 && cyc == 20)
                applyStimulus(1'b0, 1'b1, 1'b1, readyFor(mode, cyc), 10'd500);
            else
                applyStimulus(1'b0, 1'b0, 1'b1, readyFor(mode, cyc), 10'd0);
            i++;
        end
        checkOutput("done_seen", 32'(done_cnt), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 10'd0);
        checkOutput("busy_after_done", 32'(busy), 32'd0);
        checkOutput("done_width", 32'(done), 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        checkOutput({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        checkOutput({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        checkOutput({tag, "_m_data"}, 32'(m_data), 32'd0);
        checkOutput({tag, "_m_last"}, 32'(m_last), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        wr_end    = 1'b0;
        m_ready   = 1'b0;
        base_addr = '0;
        resetContext(10'd0);

        // Reset state.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
        checkResetOutputs("reset");

        // Basic run, first cycles from the vector table (start at cycle 0).
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 12'h000, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 12'h000, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 1'b0, 12'h000, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 10'd1, 1'b0, 12'h000, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 10'd2, 1'b0, 12'h000, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 10'd3, 1'b1, 12'h100, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 10'd4, 1'b1, 12'h101, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 10'd5, 1'b1, 12'h102, 1'b1};
        resetContext(10'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, vecs[i].s, vecs[i].we, vecs[i].rdy, 10'd0);
            checkOutput($sformatf("vec%0d_rd_en", i), 32'(rd_en), 32'(vecs[i].e_rd_en));
            checkOutput($sformatf("vec%0d_rd_addr", i), 32'(rd_addr), 32'(vecs[i].e_addr));
            checkOutput($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].e_valid));
            checkOutput($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(vecs[i].e_data));
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
        end
        runToDone(400, 0);
        checkOutput("basic_first_rd", 32'(first_rd), 32'd2);
        checkOutput("basic_last_rd", 32'(last_rd), 32'd257);
        checkOutput("basic_first_valid", 32'(first_valid), 32'd5);
        checkOutput("basic_done_cyc", 32'(done_cyc), 32'd261);
        checkOutput("basic_issued", 32'(n_issued), 32'd256);
        checkOutput("basic_beats", 32'(n_accepted), 32'd256);
        checkOutput("basic_last_cnt", 32'(last_cnt), 32'd1);

        // Backpressure: ready low for cycles 6..30, then toggling.
        resetContext(10'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 10'd0);
        for (int c = 1; c <= 30; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, readyFor(1, cyc), 10'd0);
        end
        checkOutput("bp_issued_at30", 32'(n_issued), 32'd5);
        checkOutput("bp_last_rd_at30", 32'(last_rd), 32'd6);
        checkOutput("bp_max_outstanding", 32'(max_out), 32'd4);
        checkOutput("bp_valid_at30", 32'(m_valid), 32'd1);
        checkOutput("bp_data_at30", 32'(m_data), 32'h101);
        runToDone(1500, 1);
        checkOutput("bp_beats", 32'(n_accepted), 32'd256);
        checkOutput("bp_last_cnt", 32'(last_cnt), 32'd1);

        // Wait for capture, then wrap from 1000 through 1023 to 231.
        resetContext(10'd1000);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 10'd1000);
        for (int c = 1; c < 15; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'd0);
        end
        checkOutput("wrap_no_early_rd", 32'(n_issued), 32'd0);
        checkOutput("wrap_busy_waiting", 32'(busy), 32'd1);
        runToDone(400, 0);
        checkOutput("wrap_first_rd", 32'(first_rd), 32'd16);
        checkOutput("wrap_beats", 32'(n_accepted), 32'd256);
        checkOutput("wrap_last_data", 32'(last_data), 32'h1E7);
        checkOutput("wrap_rd_addr_hold", 32'(rd_addr), 32'd231);

        // Abort after the 100th read.
        resetContext(10'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 10'd0);
        for (int i = 0; i < 300 && n_issued < 100; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 10'd0);
        end
        checkOutput("abort_reached_100", 32'(n_issued), 32'd100);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'd0);
        checkOutput("abort_err", 32'(err), 32'd1);
        checkOutput("abort_m_valid", 32'(m_valid), 32'd0);
        checkOutput("abort_rd_en", 32'(rd_en), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'd0);
        end
        checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
        checkOutput("abort_err_sticky", 32'(err), 32'd1);
        resetContext(10'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 10'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 10'd0);
        checkOutput("restart_err_clear", 32'(err), 32'd0);
        runToDone(400, 0);
        checkOutput("restart_beats", 32'(n_accepted), 32'd256);
        checkOutput("restart_done_cyc", 32'(done_cyc), 32'd261);

        // Reset in the middle of READ.
        resetContext(10'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 10'd0);
        for (int c = 1; c < 50; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 10'd0);
        end
        checkOutput("midrst_busy_before", 32'(busy), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 10'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 10'd0);
        checkResetOutputs("midrst");

        // Start pulsed while busy must be ignored.
        resetContext(10'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 10'd0);
        runToDone(400, 2);
        checkOutput("ignore_beats", 32'(n_accepted), 32'd256);
        checkOutput("ignore_issued", 32'(n_issued), 32'd256);
        checkOutput("ignore_done_cyc", 32'(done_cyc), 32'd261);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
